// File: rtl/shift_var.sv
`default_nettype none
// ============================================================================
// Module   : shift_var
// Brief    : Variable-length complex sample delay line built on a circular
//            buffer; delay (1..DEPTH_MAX accepted samples) is captured on
//            rst/flush. Optional macro SHIFT_ZERO_FILL_EN zeroes the data
//            outputs while do_valid is low.
// Revision : 1.0 - initial release
// ============================================================================
module shift_var #(
    parameter int DEPTH_MAX = 16,
    parameter int WIDTH     = 9,
    parameter int LEN_W     = $clog2(DEPTH_MAX) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    input  logic [LEN_W-1:0] len,
    input  logic             flush,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             do_valid,
    output logic             len_err
);

    localparam int              c_PTR_W = $clog2(DEPTH_MAX);
    localparam logic [LEN_W-1:0] c_DEPTH = LEN_W'(DEPTH_MAX);

    logic [WIDTH-1:0]   r_mem_re [DEPTH_MAX];
    logic [WIDTH-1:0]   r_mem_im [DEPTH_MAX];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [LEN_W-1:0]   r_count;
    logic [LEN_W-1:0]   r_len_q;
    logic               r_len_err;
    logic [WIDTH-1:0]   r_do_re;
    logic [WIDTH-1:0]   r_do_im;
    logic               r_do_valid;

    logic               w_accept;
    logic               w_len_bad;
    logic [LEN_W-1:0]   w_count_nxt;
    logic               w_valid_nxt;
    logic [LEN_W-1:0]   w_back;
    logic [c_PTR_W-1:0] w_rd_ptr;
    logic [WIDTH-1:0]   w_rd_re;
    logic [WIDTH-1:0]   w_rd_im;
    logic [WIDTH-1:0]   w_out_re;
    logic [WIDTH-1:0]   w_out_im;

    assign w_accept    = di_en & ~flush & ~rst;
    assign w_len_bad   = (len == '0) || (len > c_DEPTH);
    assign w_count_nxt = (r_count == c_DEPTH) ? r_count : r_count + 1'b1;
    assign w_valid_nxt = (w_count_nxt >= r_len_q);

    // The tap sits len_q-1 entries behind the write slot; a delay of one
    // bypasses the buffer since that sample is only written on this edge.
    assign w_back   = r_len_q - 1'b1;
    assign w_rd_ptr = r_wr_ptr - c_PTR_W'(w_back);
    assign w_rd_re  = (w_back == '0) ? di_re : r_mem_re[w_rd_ptr];
    assign w_rd_im  = (w_back == '0) ? di_im : r_mem_im[w_rd_ptr];

`ifdef SHIFT_ZERO_FILL_EN
    assign w_out_re = w_valid_nxt ? w_rd_re : '0;
    assign w_out_im = w_valid_nxt ? w_rd_im : '0;
`else
    assign w_out_re = w_rd_re;
    assign w_out_im = w_rd_im;
`endif

    // Buffer storage is deliberately left unreset; count gating keeps stale
    // entries from ever being flagged valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem_re[r_wr_ptr] <= di_re;
            r_mem_im[r_wr_ptr] <= di_im;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_do_re    <= '0;
            r_do_im    <= '0;
            r_do_valid <= 1'b0;
            r_len_q    <= w_len_bad ? c_DEPTH : len;
            r_len_err  <= w_len_bad;
        end else if (di_en) begin
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            r_count    <= w_count_nxt;
            r_do_re    <= w_out_re;
            r_do_im    <= w_out_im;
            r_do_valid <= w_valid_nxt;
        end
    end

    assign do_re    = r_do_re;
    assign do_im    = r_do_im;
    assign do_valid = r_do_valid;
    assign len_err  = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_shift_var.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_var
// Brief    : Scoreboard bench for shift_var: expected delayed samples are
//            queued as stimulus is driven and popped when the DUT emits them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_var;

    localparam int DEPTH_MAX = 16;
    localparam int WIDTH     = 9;
    localparam int LEN_W     = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             di_en = 1'b0;
    logic [WIDTH-1:0] di_re = '0;
    logic [WIDTH-1:0] di_im = '0;
    logic [LEN_W-1:0] len = LEN_W'(16);
    logic             flush = 1'b0;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;
    logic             do_valid;
    logic             len_err;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] hist_re[$];
    logic [WIDTH-1:0] hist_im[$];
    logic [WIDTH-1:0] sb_re[$];
    logic [WIDTH-1:0] sb_im[$];
    int               m_lq  = 16;
    int               m_cnt = 0;
    bit               m_valid = 1'b0;
    logic [WIDTH-1:0] m_re = '0;
    logic [WIDTH-1:0] m_im = '0;

    shift_var #(
        .DEPTH_MAX (DEPTH_MAX),
        .WIDTH     (WIDTH),
        .LEN_W     (LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .di_en    (di_en),
        .di_re    (di_re),
        .di_im    (di_im),
        .len      (len),
        .flush    (flush),
        .do_re    (do_re),
        .do_im    (do_im),
        .do_valid (do_valid),
        .len_err  (len_err)
    );

    always #5 clk = ~clk;

    // Capture a new delay via rst or flush, optionally with a sample that
    // must be dropped, and check the cleared outputs.
    task automatic restart(input bit use_rst, input int l, input bit en);
        bit exp_err;
        @(negedge clk);
        rst   = use_rst;
        flush = ~use_rst;
        len   = LEN_W'(l);
        di_en = en;
        di_re = 9'h155;
        di_im = 9'h0AA;
        exp_err = (l == 0) || (l > DEPTH_MAX);
        m_lq    = exp_err ? DEPTH_MAX : l;
        m_cnt   = 0;
        m_valid = 1'b0;
        m_re    = '0;
        m_im    = '0;
        hist_re.delete();
        hist_im.delete();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        flush = 1'b0;
        di_en = 1'b0;
        checks++;
        if (do_valid !== 1'b0 || do_re !== '0 || do_im !== '0) begin
            errors++;
            $display("FAIL restart_clear: valid=%0b re=%0h im=%0h, required 0/0/0",
                     do_valid, do_re, do_im);
        end
        checks++;
        if (len_err !== exp_err) begin
            errors++;
            $display("FAIL len_err(len=%0d): got %0b, required %0b", l, len_err, exp_err);
        end
        if (sb_re.size() != 0) begin
            sb_re.delete();
            sb_im.delete();
        end
    endtask

    task automatic step(input bit en, input logic [WIDTH-1:0] re);
        logic [WIDTH-1:0] im;
        bit               exp_v;
        im    = re ^ 9'h0A5;
        exp_v = 1'b0;
        @(negedge clk);
        di_en = en;
        di_re = re;
        di_im = im;
        if (en) begin
            hist_re.push_back(re);
            hist_im.push_back(im);
            if (hist_re.size() > DEPTH_MAX) begin
                void'(hist_re.pop_front());
                void'(hist_im.pop_front());
            end
            if (m_cnt < DEPTH_MAX) m_cnt++;
            exp_v = (m_cnt >= m_lq);
            if (exp_v) begin
                sb_re.push_back(hist_re[hist_re.size() - m_lq]);
                sb_im.push_back(hist_im[hist_im.size() - m_lq]);
            end
            m_valid = exp_v;
        end
        @(posedge clk);
        #1;
        di_en = 1'b0;
        if (en && exp_v) begin
            m_re = sb_re.pop_front();
            m_im = sb_im.pop_front();
        end else if (en) begin
            m_re = '0;
            m_im = '0;
        end
        checks++;
        if (do_valid !== m_valid) begin
            errors++;
            $display("FAIL valid(en=%0b in=%0d): got %0b, required %0b", en, re, do_valid, m_valid);
        end
`ifdef SHIFT_ZERO_FILL_EN
        if (1'b1) begin
`else
        if (m_valid) begin
`endif
            checks++;
            if (do_re !== m_re || do_im !== m_im) begin
                errors++;
                $display("FAIL data(en=%0b in=%0d): got %0h/%0h, required %0h/%0h",
                         en, re, do_re, do_im, m_re, m_im);
            end
        end
    endtask

    task automatic test_reset();
        restart(1'b1, 16, 1'b0);
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 40; i++) step(1'b1, WIDTH'(i));
    endtask

    task automatic test_len1();
        restart(1'b1, 1, 1'b0);
        step(1'b1, 9'd5);
        step(1'b1, 9'd6);
        step(1'b1, 9'd7);
    endtask

    task automatic test_gaps();
        logic [WIDTH-1:0] data [8];
        bit               ens  [8];
        data = '{9'd10, 9'd11, 9'h1FF, 9'd12, 9'h1FF, 9'h1FF, 9'd13, 9'd14};
        ens  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        restart(1'b0, 4, 1'b0);
        for (int i = 0; i < 8; i++) step(ens[i], data[i]);
    endtask

    task automatic test_flush();
        restart(1'b0, 4, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, WIDTH'(100 + i));
        len = LEN_W'(2);
        for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(120 + i));
        restart(1'b0, 8, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, WIDTH'(200 + i));
    endtask

    task automatic test_len_err();
        restart(1'b0, 0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, WIDTH'(300 + i));
        restart(1'b0, 17, 1'b0);
        for (int i = 0; i < 18; i++) step(i != 7, WIDTH'(340 + i));
        restart(1'b0, 5, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(400 + i));
    endtask

    task automatic test_reset_mid();
        restart(1'b1, 3, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, WIDTH'(450 + i));
        restart(1'b1, 3, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(470 + i));
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_len1();
        test_gaps();
        test_flush();
        test_len_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
